// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and TX state encoding.
package uart_pkg;

    localparam logic [3:0] OFF_TXDATA  = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_BAUDDIV = 4'h8;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // The STATUS count field is 4 bits wide; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'd15 : c[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards any queued contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: bus decode, registers, TX FIFO and shift FSM.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read_mem,
    input  logic        cpu_write_mem,
    input  logic [31:0] addr,
    input  logic [31:0] idata_from_cpu,
    output logic [31:0] odata_to_cpu,
    output logic        error,
    output logic        tx,
    output logic        irq_empty
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [3:0]    off;
    logic [15:0]   baud_div;
    logic [15:0]   eff_div;
    logic [31:0]   status;
    logic [31:0]   rdata_n;
    logic          err_n;
    logic          push_ok;
    logic          baud_we;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;

    tx_state_t     state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift_reg, shift_n;
    logic [15:0]   div_lat, div_n;
    logic          pop;
    logic          load;
    logic          tx_n;
    logic          busy;
    logic          unused_wdata;

    assign sel          = (addr[31:4] == BASE_ADDR[31:4]) & (cpu_read_mem | cpu_write_mem);
    assign off          = addr[3:0];
    assign eff_div      = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign busy         = (state != S_IDLE);
    assign count_next   = fifo_count + CW'(push_ok) - CW'(pop);
    assign unused_wdata = ^idata_from_cpu[31:16];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .din   (idata_from_cpu[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // STATUS word assembled from live FIFO/FSM state.
    always_comb begin
        status                         = '0;
        status[ST_BUSY]                = busy;
        status[ST_FULL]                = fifo_full;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_COUNT_LSB +: 4]      = sat_count(32'(fifo_count));
    end

    // Bus decode: read data, access errors, FIFO push and divisor write enables.
    always_comb begin
        rdata_n = '0;
        err_n   = 1'b0;
        push_ok = 1'b0;
        baud_we = 1'b0;
        if (sel) begin
            if (cpu_read_mem && cpu_write_mem) begin
                err_n = 1'b1;
            end else if (cpu_read_mem) begin
                case (off)
                    OFF_TXDATA:  rdata_n = '0;
                    OFF_STATUS:  rdata_n = status;
                    OFF_BAUDDIV: rdata_n = {16'h0, baud_div};
                    default:     err_n   = 1'b1;
                endcase
            end else begin
                case (off)
                    OFF_TXDATA: begin
                        if (fifo_full && !pop) err_n   = 1'b1;
                        else                   push_ok = 1'b1;
                    end
                    OFF_BAUDDIV: baud_we = 1'b1;
                    default:     err_n   = 1'b1;
                endcase
            end
        end
    end

    // Registered bus response and the divisor register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            odata_to_cpu <= '0;
            error        <= 1'b0;
            baud_div     <= DEFAULT_DIV;
        end else begin
            odata_to_cpu <= rdata_n;
            error        <= err_n;
            if (baud_we) baud_div <= idata_from_cpu[15:0];
        end
    end

    // TX FSM next state; STOP may chain straight into the next START when bytes are waiting.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift_reg;
        div_n   = div_lat;
        pop     = 1'b0;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                load = ~fifo_empty;
            end
            S_START: begin
                if (cnt == 16'd0) begin
                    state_n = S_DATA;
                    idx_n   = 3'd0;
                    cnt_n   = div_lat - 16'd1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt == 16'd0) begin
                    cnt_n = div_lat - 16'd1;
                    if (idx == 3'd7) state_n = S_STOP;
                    else             idx_n   = idx + 3'd1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt == 16'd0) begin
                    state_n = S_IDLE;
                    load    = ~fifo_empty;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (load) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            div_n   = eff_div;
            cnt_n   = eff_div - 16'd1;
            state_n = S_START;
        end
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shift_n[idx_n];
            default: tx_n = 1'b1;
        endcase
    end

    // FSM control registers; tx and irq_empty are registered from next-state values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            tx        <= 1'b1;
            irq_empty <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            tx        <= tx_n;
            irq_empty <= (count_next == '0) && (state_n == S_IDLE);
        end
    end

    // Frame data and latched divisor, only meaningful while a frame is active.
    always_ff @(posedge clk) begin
        shift_reg <= shift_n;
        div_lat   <= div_n;
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench: bus responses and serial frames are predicted and checked by monitors.
module tb_uart_tx_periph;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_read_mem = 1'b0;
    logic        cpu_write_mem = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] idata_from_cpu = '0;
    logic [31:0] odata_to_cpu;
    logic        error;
    logic        tx;
    logic        irq_empty;

    uart_tx_periph dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_read_mem   (cpu_read_mem),
        .cpu_write_mem  (cpu_write_mem),
        .addr           (addr),
        .idata_from_cpu (idata_from_cpu),
        .odata_to_cpu   (odata_to_cpu),
        .error          (error),
        .tx             (tx),
        .irq_empty      (irq_empty)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  frame_q[$];
    logic [15:0] mdl_baud = 16'd868;
    bit          mon_busy = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int eff(input logic [15:0] b);
        return (b == 16'd0) ? 1 : int'(b);
    endfunction

    // Expected line level at clock i of an 8N1 frame of byte b with d clocks per bit.
    function automatic logic level(input logic [7:0] b, input int d, input int i);
        int slot;
        slot = i / d;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    // Bus monitor: one registered response per strobe, zeros otherwise.
    logic        bm_strobe;
    logic [32:0] bm_e;
    initial begin
        forever begin
            @(posedge clk);
            bm_strobe = cpu_read_mem | cpu_write_mem;
            @(negedge clk);
            if (bm_strobe) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL bus_resp: response with no access pending, want none");
                end else begin
                    bm_e = exp_q.pop_front();
                    chk("bus_odata", odata_to_cpu, bm_e[31:0]);
                    chk("bus_error", 32'(error), 32'(bm_e[32]));
                end
            end else begin
                chk("idle_odata", odata_to_cpu, 32'h0);
                chk("idle_error", 32'(error), 32'h0);
            end
        end
    end

    // Serial monitor: each falling tx starts a frame compared clock by clock.
    logic [7:0] fm_b;
    int         fm_d;
    int         fm_bad;
    bit         fm_abort;
    initial begin
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                if (frame_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL frame_unexpected: tx low with no byte queued, want idle high");
                    for (int k = 0; k < 20000 && tx === 1'b0; k++) @(negedge clk);
                end else begin
                    fm_b     = frame_q.pop_front();
                    fm_d     = eff(mdl_baud);
                    mon_busy = 1'b1;
                    fm_bad   = 0;
                    fm_abort = 1'b0;
                    for (int i = 0; i < 10 * fm_d; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!rst) begin
                            fm_abort = 1'b1;
                            break;
                        end
                        if (tx !== level(fm_b, fm_d, i)) fm_bad++;
                    end
                    mon_busy = 1'b0;
                    if (!fm_abort)
                        chk($sformatf("frame_%02h_div%0d_badclocks", fm_b, fm_d), 32'(fm_bad), 32'h0);
                end
            end
        end
    end

    task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e);
        cpu_read_mem   = rd;
        cpu_write_mem  = wr;
        addr           = a;
        idata_from_cpu = d;
        exp_q.push_back({exp_e, exp_d});
        @(negedge clk);
        cpu_read_mem   = 1'b0;
        cpu_write_mem  = 1'b0;
    endtask

    task automatic reg_wr(input logic [3:0] off, input logic [31:0] d, input logic exp_e);
        bus(1'b0, 1'b1, BASE | {28'h0, off}, d, 32'h0, exp_e);
    endtask

    task automatic reg_rd(input logic [3:0] off, input logic [31:0] exp_d, input logic exp_e);
        bus(1'b1, 1'b0, BASE | {28'h0, off}, 32'h0, exp_d, exp_e);
    endtask

    task automatic set_baud(input logic [15:0] b);
        reg_wr(4'h8, {16'hDEAD, b}, 1'b0);
        mdl_baud = b;
    endtask

    task automatic send(input logic [7:0] b);
        frame_q.push_back(b);
        reg_wr(4'h0, {24'hABCDEF, b}, 1'b0);
    endtask

    task automatic wait_drain(input int max_cyc);
        int k;
        k = 0;
        while ((frame_q.size() != 0 || mon_busy) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (k >= max_cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: frames pending after %0d clocks, want drained", k);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: run still active at time %0t, want finished", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

    logic [3:0]  r_off;
    logic [31:0] r_hi;
    int          r_op;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_irq_empty", 32'(irq_empty), 32'h1);
        chk("rst_odata", odata_to_cpu, 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Register reads and access errors
        reg_rd(4'h8, 32'd868, 1'b0);
        reg_rd(4'h4, 32'h4, 1'b0);
        reg_rd(4'h0, 32'h0, 1'b0);
        reg_rd(4'hC, 32'h0, 1'b1);
        reg_wr(4'h4, 32'hFFFF_FFFF, 1'b1);
        bus(1'b1, 1'b0, BASE + 32'h10, 32'h0, 32'h0, 1'b0);
        bus(1'b1, 1'b0, BASE - 32'h8, 32'h0, 32'h0, 1'b0);
        bus(1'b1, 1'b1, BASE | 32'h8, 32'h5, 32'h0, 1'b1);
        reg_rd(4'h8, 32'd868, 1'b0);

        // 0xA5 at divisor 4
        set_baud(16'd4);
        send(8'hA5);
        chk("irq_after_push", 32'(irq_empty), 32'h0);
        wait_drain(5000);
        chk("irq_after_frame", 32'(irq_empty), 32'h1);
        chk("tx_after_frame", 32'(tx), 32'h1);
        reg_rd(4'h4, 32'h4, 1'b0);

        // Divisor change mid-frame applies only to the next frame
        set_baud(16'd2);
        send(8'h01);
        send(8'hC3);
        repeat (8) @(negedge clk);
        set_baud(16'd3);
        wait_drain(5000);

        // Divisor 0 behaves as 1
        set_baud(16'd0);
        reg_rd(4'h8, 32'h0, 1'b0);
        send(8'hFF);
        wait_drain(5000);

        // Randomized traffic
        for (int n = 0; n < 90; n++) begin
            if (n % 15 == 0) begin
                wait_drain(5000);
                reg_rd(4'h4, 32'h4, 1'b0);
                set_baud(16'($urandom_range(0, 5)));
            end
            r_op = $urandom_range(0, 9);
            case (r_op)
                0, 1, 2, 3: begin
                    if (frame_q.size() < DEPTH) send(8'($urandom));
                    else @(negedge clk);
                end
                4: reg_rd(4'h8, {16'h0, mdl_baud}, 1'b0);
                5: reg_rd(4'h0, 32'h0, 1'b0);
                6: begin
                    do r_off = 4'($urandom_range(0, 15));
                    while (r_off == 4'h0 || r_off == 4'h4 || r_off == 4'h8);
                    if ($urandom_range(0, 1) == 0) reg_rd(r_off, 32'h0, 1'b1);
                    else                           reg_wr(r_off, $urandom, 1'b1);
                end
                7: begin
                    r_hi = $urandom;
                    if (r_hi[31:4] == BASE[31:4]) r_hi[31] = ~r_hi[31];
                    r_off = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h8;
                    bus($urandom_range(0, 1) == 0, 1'b1, {r_hi[31:4], r_off}, $urandom, 32'h0, 1'b0);
                end
                8: begin
                    r_off = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h8;
                    bus(1'b1, 1'b1, BASE | {28'h0, r_off}, $urandom, 32'h0, 1'b1);
                end
                default: @(negedge clk);
            endcase
        end
        wait_drain(5000);
        reg_rd(4'h8, {16'h0, mdl_baud}, 1'b0);

        // Overfill with a slow divisor, then reset mid-frame
        set_baud(16'd1000);
        send(8'h00);
        for (int i = 1; i < 9; i++) send(8'($urandom));
        reg_wr(4'h0, 32'h5A, 1'b1);
        reg_rd(4'h4, 32'h83, 1'b0);
        repeat (1500) @(negedge clk);
        chk("tx_in_data_before_reset", 32'(tx), 32'h0);
        #2;
        rst = 1'b0;
        frame_q.delete();
        mdl_baud = 16'd868;
        #1;
        chk("tx_async_reset", 32'(tx), 32'h1);
        chk("irq_async_reset", 32'(irq_empty), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reg_rd(4'h4, 32'h4, 1'b0);
        reg_rd(4'h8, 32'd868, 1'b0);
        repeat (4) @(negedge clk);
        chk("tx_idle_end", 32'(tx), 32'h1);
        chk("bus_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
